// File: rtl/microseq_pkg.sv
// Shared widths, state encoding and helpers for the micro_sequencer block.
package microseq_pkg;

    localparam int ADDR_W  = 9;
    localparam int INSTR_W = 29;
    localparam int CNT_W   = 10;

    // Unprogrammed ROM locations read as all-zero and are skipped as NOPs.
    localparam logic [INSTR_W-1:0] NOP_WORD = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Control, ROM and datapath signals of the micro_sequencer, seen from the sequencer (master)
// and from its parent / datapath (slave).
interface micro_sequencer_if;
    import microseq_pkg::*;

    logic               start;
    logic [ADDR_W-1:0]  start_addr;
    logic [ADDR_W-1:0]  end_addr;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic               exec_done;
    logic               busy;
    logic               done;
    logic               err;
    logic [CNT_W-1:0]   instr_cnt;

    modport master (
        input  start, start_addr, end_addr, rom_data, instr_ready, exec_done,
        output rom_addr, instr, instr_valid, busy, done, err, instr_cnt
    );

    modport slave (
        output start, start_addr, end_addr, rom_data, instr_ready, exec_done,
        input  rom_addr, instr, instr_valid, busy, done, err, instr_cnt
    );

endinterface

// File: rtl/micro_sequencer.sv
// Microcode sequencer: walks one routine through a registered-read ROM and hands each word to the
// datapath. Define MICROSEQ_PREFETCH_EN to prefetch the next word while waiting for exec_done.
module micro_sequencer
    import microseq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    micro_sequencer_if.master io_bus
);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_end;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [INSTR_W-1:0] r_instr;
    logic               r_instr_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [CNT_W-1:0]   r_instr_cnt;
`ifdef MICROSEQ_PREFETCH_EN
    logic               r_pf_valid;
`endif

    logic [ADDR_W-1:0]  w_pc_inc;
    logic               w_at_end;

    // pc only advances while pc != end, so it can never wrap past 511.
    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_at_end = (r_pc == r_end);

    // NOTE: every register in this block is updated with non-blocking assignments so all
    // transitions see the same pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_end         <= '0;
            r_rom_addr    <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_instr_cnt   <= '0;
`ifdef MICROSEQ_PREFETCH_EN
            r_pf_valid    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_busy <= 1'b1;
                        if (io_bus.start_addr > io_bus.end_addr) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_pc        <= io_bus.start_addr;
                            r_end       <= io_bus.end_addr;
                            r_rom_addr  <= io_bus.start_addr;
                            r_instr_cnt <= '0;
                            r_err       <= 1'b0;
                            r_state     <= S_FETCH;
                        end
                    end
                end

                // rom_addr was loaded on entry; this cycle lets the ROM register it.
                S_FETCH: r_state <= S_LATCH;

                S_LATCH: begin
                    if (io_bus.rom_data == NOP_WORD) begin
                        if (w_at_end) begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_pc       <= w_pc_inc;
                            r_rom_addr <= w_pc_inc;
                            r_state    <= S_FETCH;
                        end
                    end else begin
                        r_instr       <= io_bus.rom_data;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (io_bus.instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_instr_cnt   <= sat_inc(r_instr_cnt);
                        r_state       <= S_WAIT;
`ifdef MICROSEQ_PREFETCH_EN
                        r_pf_valid    <= 1'b0;
                        if (!w_at_end) r_rom_addr <= w_pc_inc;
`endif
                    end
                end

`ifdef MICROSEQ_PREFETCH_EN
                // Prefetched data is usable once rom_addr has been held for a full WAIT cycle.
                S_WAIT: begin
                    if (io_bus.exec_done) begin
                        if (w_at_end) begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else if (!r_pf_valid) begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_LATCH;
                        end else if (io_bus.rom_data == NOP_WORD) begin
                            if (w_pc_inc == r_end) begin
                                r_done  <= 1'b1;
                                r_state <= S_FINISH;
                            end else begin
                                r_pc       <= r_pc + ADDR_W'(2);
                                r_rom_addr <= r_pc + ADDR_W'(2);
                                r_state    <= S_FETCH;
                            end
                        end else begin
                            r_pc          <= w_pc_inc;
                            r_instr       <= io_bus.rom_data;
                            r_instr_valid <= 1'b1;
                            r_state       <= S_ISSUE;
                        end
                    end else begin
                        r_pf_valid <= 1'b1;
                    end
                end
`else
                S_WAIT: begin
                    if (io_bus.exec_done) begin
                        if (w_at_end) begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_pc       <= w_pc_inc;
                            r_rom_addr <= w_pc_inc;
                            r_state    <= S_FETCH;
                        end
                    end
                end
`endif

                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.rom_addr    = r_rom_addr;
    assign io_bus.instr       = r_instr;
    assign io_bus.instr_valid = r_instr_valid;
    assign io_bus.busy        = r_busy;
    assign io_bus.done        = r_done;
    assign io_bus.err         = r_err;
    assign io_bus.instr_cnt   = r_instr_cnt;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: ROM and datapath models plus a routine-level reference
// model (expected word list per routine) checked every cycle.
module tb_micro_sequencer;
    import microseq_pkg::*;

`ifdef MICROSEQ_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    micro_sequencer_if bus ();

    micro_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // ROM contents: addr k holds 29'h1000000 + k, except addr 5 which is left blank.
    function automatic logic [INSTR_W-1:0] rom_word(input int unsigned a);
        return (a == 5) ? '0 : INSTR_W'(32'h1000000 + a);
    endfunction

    always @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model state
    int                 exp_q[$];
    logic [INSTR_W-1:0] acc_log[$];
    int  m_cnt = 0;
    bit  m_err = 0;
    bit  rt_active = 0;
    bit  prev_valid = 0, prev_ready = 0, prev_done = 0;
    logic [INSTR_W-1:0] prev_instr = '0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  trig_cyc = 0, exp_lat = 0, acc_cyc = 0, last_addr = 0;
    bit  lat_armed = 0, trig_is_exec = 0;
    int  meas_exec_lat = -1, meas_start_lat = -1;

    // Datapath model
    int exec_dly  = 2;
    int cd        = 0;
    int hold_left = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && bus.instr_valid && bus.instr_ready) cd = exec_dly;
    end

    initial begin
        bus.instr_ready = 1'b1;
        bus.exec_done   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.exec_done = 1'b0;
            if (!rst_n) cd = 0;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) bus.exec_done = 1'b1;
            end
            if (hold_left > 0) begin
                bus.instr_ready = 1'b0;
                if (bus.instr_valid) hold_left--;
            end else begin
                bus.instr_ready = 1'b1;
            end
        end
    end

    // Compare process: outputs checked first against pre-edge model state, then the model advances.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_cnt      = 0;
            m_err      = 0;
            rt_active  = 0;
            prev_valid = 0;
            prev_ready = 0;
            prev_done  = 0;
            lat_armed  = 0;
        end else begin
            check("busy", bus.busy, rt_active);
            check("err", bus.err, m_err);
            check("instr_cnt", bus.instr_cnt, m_cnt);
            if (prev_valid && !prev_ready) begin
                check("valid_held", bus.instr_valid, 1);
                check("instr_held", bus.instr, prev_instr);
            end
            if (bus.instr_valid) begin
                if (exp_q.size() == 0) begin
                    check("valid_unexpected", bus.instr_valid, 0);
                end else begin
                    check("instr", bus.instr, rom_word(exp_q[0]));
                    if (!prev_valid && lat_armed) begin
                        check("latency", cyc - trig_cyc, exp_lat);
                        if (trig_is_exec) meas_exec_lat = cyc - trig_cyc;
                        else              meas_start_lat = cyc - trig_cyc;
                    end
                    if (bus.instr_ready) begin
                        acc_log.push_back(bus.instr);
                        last_addr = exp_q.pop_front();
                        m_cnt     = (m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1;
                        acc_cyc   = cyc;
                    end
                end
            end
            if (!prev_valid && bus.instr_valid) lat_armed = 0;

            if (bus.exec_done && rt_active && exp_q.size() > 0 && exp_q[0] == last_addr + 1) begin
                trig_cyc     = cyc;
                trig_is_exec = 1;
                exp_lat      = PF ? ((cyc == acc_cyc + 1) ? 2 : 1) : 3;
                lat_armed    = 1;
            end

            if (bus.start && !rt_active) begin
                rt_active = 1;
                if (bus.start_addr > bus.end_addr) begin
                    m_err = 1;
                end else begin
                    m_err = 0;
                    m_cnt = 0;
                    for (int a = bus.start_addr; a <= bus.end_addr; a++)
                        if (rom_word(a) != '0) exp_q.push_back(a);
                    last_addr = bus.start_addr - 1;
                    if (exp_q.size() > 0 && exp_q[0] == bus.start_addr) begin
                        trig_cyc     = cyc;
                        trig_is_exec = 0;
                        exp_lat      = 3;
                        lat_armed    = 1;
                    end
                end
            end

            if (bus.done) begin
                check("done_single_cycle", prev_done, 0);
                check("done_at_routine_end", rt_active && exp_q.size() == 0, 1);
                done_cnt++;
                rt_active = 0;
            end

            prev_valid = bus.instr_valid;
            prev_ready = bus.instr_ready;
            prev_instr = bus.instr;
            prev_done  = bus.done;
        end
    end

    task automatic run_routine(input int s, input int e, input int extra_at);
        int d0;
        d0 = done_cnt;
        acc_log.delete();
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.start_addr = ADDR_W'(s);
        bus.end_addr   = ADDR_W'(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
            if (i == extra_at) begin
                bus.start      = 1'b1;
                bus.start_addr = ADDR_W'(0);
                bus.end_addr   = ADDR_W'(9);
                @(posedge clk);
                #1;
                bus.start = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("done_pulses", done_cnt - d0, 1);
        check("queue_drained", exp_q.size(), 0);
        check("busy_after_done", bus.busy, 0);
        check("done_after_done", bus.done, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, e, d0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.end_addr   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rom_addr", bus.rom_addr, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_instr_cnt", bus.instr_cnt, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Routine 0..3, ready tied high, exec_done two cycles after accept
        exec_dly = 2;
        run_routine(0, 3, -1);
        check("r03_words", acc_log.size(), 4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++)
            check("r03_instr", acc_log[i], 29'h1000000 + i);
        check("r03_cnt", bus.instr_cnt, 4);
        check("start_to_valid", meas_start_lat, 3);

        // Routine 4..6: blank word at 5 skipped
        run_routine(4, 6, -1);
        check("r46_words", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            check("r46_first", acc_log[0], 29'h1000004);
            check("r46_second", acc_log[1], 29'h1000006);
        end
        check("r46_cnt", bus.instr_cnt, 2);

        // Reversed range flags err and finishes without issuing
        run_routine(7, 3, -1);
        check("bad_range_words", acc_log.size(), 0);
        check("bad_range_err", bus.err, 1);

        // Next valid start clears err
        run_routine(0, 0, -1);
        check("single_err", bus.err, 0);
        check("single_words", acc_log.size(), 1);
        check("single_cnt", bus.instr_cnt, 1);

        // Back-pressure for 5 cycles plus an ignored start mid-routine
        hold_left = 5;
        run_routine(8, 10, 4);
        check("hold_words", acc_log.size(), 3);

        // Top of the address space: no wrap
        run_routine(510, 511, -1);
        check("top_words", acc_log.size(), 2);
        if (acc_log.size() == 2) check("top_last", acc_log[1], 29'h10001FF);

        // exec_done three cycles after accept: measure exec_done to next instr_valid
        exec_dly      = 3;
        meas_exec_lat = -1;
        run_routine(0, 3, -1);
        check("exec_to_valid", meas_exec_lat, PF ? 1 : 3);

        // Reset while waiting for exec_done
        exec_dly = 10;
        d0       = done_cnt;
        acc_log.delete();
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.start_addr = ADDR_W'(0);
        bus.end_addr   = ADDR_W'(3);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < 50 && acc_log.size() == 0; i++) @(negedge clk);
        check("mid_rst_accepted", acc_log.size(), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_rom_addr", bus.rom_addr, 0);
        check("mid_rst_instr", bus.instr, 0);
        check("mid_rst_valid", bus.instr_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_cnt", bus.instr_cnt, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_idle", bus.busy, 0);

        // Randomized routines
        for (int n = 0; n < 40; n++) begin
            s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(500, 511)) : int'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0 && s > 0) e = int'($urandom_range(0, s - 1));
            else e = s + int'($urandom_range(0, 6));
            if (e > 511) e = 511;
            exec_dly  = int'($urandom_range(1, 4));
            hold_left = int'($urandom_range(0, 3));
            run_routine(s, e, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
